// File: rtl/fw_unit.sv
// fw_unit -- forwarding and hazard unit for the dual-issue SPU-Lite pipeline.
//
// Tracks every in-flight register write in a per-pipe tag shift register
// (valid, destination, ready stage). For each source operand it finds the youngest
// matching in-flight result. If that result already exists, its stage data is
// forwarded. If it does not exist yet, the issuing pipe stalls.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   iss_valid    per pipe: instruction issuing this cycle
//   iss_wr_en    per pipe: issuing instruction writes a register
//   iss_rt       per pipe: destination register
//   iss_rdy_stg  per pipe: first tracked stage at which the result is valid
//   src_addr     per pipe/source: source register address (pipe-major packing)
//   src_used     per pipe/source: source is actually read
//   rf_data      per pipe/source: register-file read data
//   stg_data     per pipe/stage: result data available in that stage
//   flush        kill in-flight entries that land in stages 0..1
//   fw_data      per pipe/source: forwarded operand
//   stall        per pipe: issue must hold
//   stall_cnt    saturating count of cycles with any stall bit set
module fw_unit #(
  parameter int NUM_PIPES = 2,
  parameter int NUM_SRC   = 3,
  parameter int DEPTH     = 6,
  parameter int ADDR_WD   = 7,
  parameter int DATA_WD   = 128,
  parameter int LAT_WD    = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PIPES-1:0]                 iss_valid,
  input  logic [NUM_PIPES-1:0]                 iss_wr_en,
  input  logic [NUM_PIPES*ADDR_WD-1:0]         iss_rt,
  input  logic [NUM_PIPES*LAT_WD-1:0]          iss_rdy_stg,
  input  logic [NUM_PIPES*NUM_SRC*ADDR_WD-1:0] src_addr,
  input  logic [NUM_PIPES*NUM_SRC-1:0]         src_used,
  input  logic [NUM_PIPES*NUM_SRC*DATA_WD-1:0] rf_data,
  input  logic [NUM_PIPES*DEPTH*DATA_WD-1:0]   stg_data,
  input  logic                                 flush,
  output logic [NUM_PIPES*NUM_SRC*DATA_WD-1:0] fw_data,
  output logic [NUM_PIPES-1:0]                 stall,
  output logic [31:0]                          stall_cnt
);

  localparam int NSRC_ALL = NUM_PIPES * NUM_SRC;
  localparam logic [LAT_WD-1:0] LAST_STG = LAT_WD'(DEPTH - 1);

  logic                tag_vld_q [NUM_PIPES][DEPTH];
  logic                tag_vld_d [NUM_PIPES][DEPTH];
  logic [ADDR_WD-1:0]  tag_rt_q  [NUM_PIPES][DEPTH];
  logic [ADDR_WD-1:0]  tag_rt_d  [NUM_PIPES][DEPTH];
  logic [LAT_WD-1:0]   tag_rdy_q [NUM_PIPES][DEPTH];
  logic [LAT_WD-1:0]   tag_rdy_d [NUM_PIPES][DEPTH];
  logic [31:0]         stall_cnt_q;
  logic [31:0]         stall_cnt_d;
  logic [NSRC_ALL-1:0] src_stall;

  // Tag shift: stage 0 takes the new issue. A stalled pipe loads a bubble.
  // Flush kills whatever lands in stages 0 and 1, including the new issue.
  always_comb begin
    for (int p = 0; p < NUM_PIPES; p++) begin
      tag_vld_d[p][0] = iss_valid[p] & iss_wr_en[p] & ~stall[p] & ~flush;
      tag_rt_d[p][0]  = iss_rt[p*ADDR_WD +: ADDR_WD];
      tag_rdy_d[p][0] = iss_rdy_stg[p*LAT_WD +: LAT_WD];
      for (int k = 1; k < DEPTH; k++) begin
        tag_vld_d[p][k] = tag_vld_q[p][k-1] & ~(flush && (k == 1));
        tag_rt_d[p][k]  = tag_rt_q[p][k-1];
        tag_rdy_d[p][k] = tag_rdy_q[p][k-1];
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|stall) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        for (int k = 0; k < DEPTH; k++) begin
          tag_vld_q[p][k] <= 1'b0;
          tag_rt_q[p][k]  <= '0;
          tag_rdy_q[p][k] <= '0;
        end
      end
      stall_cnt_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        for (int k = 0; k < DEPTH; k++) begin
          tag_vld_q[p][k] <= tag_vld_d[p][k];
          tag_rt_q[p][k]  <= tag_rt_d[p][k];
          tag_rdy_q[p][k] <= tag_rdy_d[p][k];
        end
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Per-source winner search. The scan runs from the oldest stage to the
  // youngest and from the lowest pipe to the highest. The last hit therefore
  // has the lowest stage and, within that stage, the highest pipe. Only
  // registered tags are searched, so a same-cycle issue on a lower pipe is
  // never forwarded.
  for (genvar gi = 0; gi < NSRC_ALL; gi++) begin : g_src
    logic               hit;
    logic [LAT_WD-1:0]  win_k;
    logic [LAT_WD-1:0]  win_rdy;
    logic [LAT_WD-1:0]  rdy_eff;
    logic [DATA_WD-1:0] win_data;
    logic               unready;

    always_comb begin
      hit      = 1'b0;
      win_k    = '0;
      win_rdy  = '0;
      win_data = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        for (int q = 0; q < NUM_PIPES; q++) begin
          if (src_used[gi] && tag_vld_q[q][k] &&
              (tag_rt_q[q][k] == src_addr[gi*ADDR_WD +: ADDR_WD])) begin
            hit      = 1'b1;
            win_k    = LAT_WD'(k);
            win_rdy  = tag_rdy_q[q][k];
            win_data = stg_data[(q*DEPTH + k)*DATA_WD +: DATA_WD];
          end
        end
      end
    end

    // A ready stage beyond the tracked window means the result is ready at the last stage.
    assign rdy_eff = (win_rdy > LAST_STG) ? LAST_STG : win_rdy;
    assign unready = hit && (win_k < rdy_eff);
    assign src_stall[gi] = unready;
    assign fw_data[gi*DATA_WD +: DATA_WD] =
      (hit && !unready) ? win_data : rf_data[gi*DATA_WD +: DATA_WD];
  end

  for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_stall
    assign stall[gi] = |src_stall[gi*NUM_SRC +: NUM_SRC];
  end

  assign stall_cnt = stall_cnt_q;

endmodule
